// File: rtl/led_toggle_demux_n_if.sv
// ============================================================================
// led_toggle_demux_n_if: enable/select/output bundle for led_toggle_demux_n.
// i_Mode exists only when LED_LFSR_MODE_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

interface led_toggle_demux_n_if #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic              i_Enable;
  logic [SEL_W-1:0]  i_Sel;
  logic [NUM_CH-1:0] o_Data;
  logic              o_Toggle;
  logic              o_Busy;
`ifdef LED_LFSR_MODE_EN
  logic              i_Mode;

  modport master (output i_Enable, i_Sel, i_Mode, input o_Data, o_Toggle, o_Busy);
  modport slave  (input i_Enable, i_Sel, i_Mode, output o_Data, o_Toggle, o_Busy);
`else
  modport master (output i_Enable, i_Sel, input o_Data, o_Toggle, o_Busy);
  modport slave  (input i_Enable, i_Sel, output o_Data, o_Toggle, o_Busy);
`endif
endinterface

`default_nettype wire

// File: rtl/led_toggle_demux_n.sv
// ============================================================================
// led_toggle_demux_n: prescaled blink source with glitch-free 1-to-N demux.
// Optional LFSR pattern mode: define LED_LFSR_MODE_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module led_toggle_demux_n #(
  parameter int NUM_CH      = 4,
  parameter int SEL_W       = 2,
  parameter int COUNT_LIMIT = 4194303,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic            i_Clk,
  input  wire logic            i_Rst,
  led_toggle_demux_n_if.slave  bus
);

  localparam int c_CNT_W = (COUNT_LIMIT > 0) ? $clog2(COUNT_LIMIT + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(COUNT_LIMIT);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sync_q [SYNC_STAGES];
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;
  logic                tog_q, tog_d;
  logic [SEL_W-1:0]    act_q, act_d;
  logic [NUM_CH-1:0]   data_q, data_d;
  logic                tog_o_q;
  logic [SEL_W-1:0]    w_sel_s;
  logic                w_wrap;
`ifdef LED_LFSR_MODE_EN
  logic [7:0]          lfsr_q, lfsr_d;
  logic                w_lfsr_fb;

  assign w_lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
`endif

  // Select comes straight from board switches
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.i_Sel;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign w_sel_s = sync_q[SYNC_STAGES-1];
  assign w_wrap  = bus.i_Enable && (cnt_q == c_LIMIT);

  always_comb begin
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    act_d   = act_q;
    state_d = state_q;
`ifdef LED_LFSR_MODE_EN
    lfsr_d  = lfsr_q;
`endif
    if (w_wrap) begin
      cnt_d  = '0;
`ifdef LED_LFSR_MODE_EN
      tog_d  = bus.i_Mode ? lfsr_q[0] : ~tog_q;
      lfsr_d = {lfsr_q[6:0], w_lfsr_fb};
`else
      tog_d  = ~tog_q;
`endif
    end else if (bus.i_Enable) begin
      cnt_d = cnt_q + 1'b1;
    end

    // A switch overrides any same-cycle wrap so the new channel opens low
    case (state_q)
      S_RUN: begin
        if (w_sel_s != act_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_sel_s == act_q) begin
          state_d = S_RUN;
        end else if (!tog_q) begin
          act_d   = w_sel_s;
          cnt_d   = '0;
          tog_d   = 1'b0;
          state_d = S_RUN;
        end else if (!bus.i_Enable) begin
          tog_d = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    data_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (act_q == SEL_W'(k)) data_d[k] = tog_q;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      tog_q   <= 1'b0;
      act_q   <= '0;
      data_q  <= '0;
      tog_o_q <= 1'b0;
`ifdef LED_LFSR_MODE_EN
      lfsr_q  <= 8'h01;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      act_q   <= act_d;
      data_q  <= data_d;
      tog_o_q <= tog_q;
`ifdef LED_LFSR_MODE_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign bus.o_Data   = data_q;
  assign bus.o_Toggle = tog_o_q;
  assign bus.o_Busy   = (state_q == S_DRAIN);

endmodule

`default_nettype wire
